// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, packetizer FSM states and
// head-flit field placement, so the flit encoder and decoder agree.
package noc_pkg;

   localparam int FLIT_TYPE_W = 2;

   // Flit type, carried in the two MSBs of every flit.
   typedef enum logic [1:0] {
      FT_HEAD      = 2'b00,
      FT_BODY      = 2'b01,
      FT_TAIL      = 2'b10,
      FT_HEAD_TAIL = 2'b11
   } flit_type_e;

   // Packetizer FSM states.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HEAD = 2'b01,
      S_BODY = 2'b10
   } pkt_state_e;

   // Full flit width for a given payload word width.
   function automatic int flit_w(input int data_w);
      return data_w + FLIT_TYPE_W;
   endfunction

   // MSB of the destination X field inside a head payload.
   function automatic int head_x_msb(input int data_w);
      return data_w - 1;
   endfunction

   // MSB of the destination Y field: directly below the X field.
   function automatic int head_y_msb(input int data_w, input int x_w);
      return data_w - 1 - x_w;
   endfunction

endpackage

// File: rtl/flit_out_reg.sv
// One-entry output holding register with valid/ready handshake.
// A flit transfers on a cycle where flit_valid_o && flit_ready_i. While
// valid is high and ready is low, contents are held stable. The register is
// "free" (may accept a new flit) when it is empty or draining this cycle.
module flit_out_reg #(
   parameter int FLIT_W = 34,
   parameter int VC_W   = 1
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              load_i,
   input  logic [FLIT_W-1:0] flit_d_i,
   input  logic [VC_W-1:0]   vc_d_i,
   input  logic              flit_ready_i,
   output logic              free_o,
   output logic              flit_valid_o,
   output logic [FLIT_W-1:0] flit_o,
   output logic [VC_W-1:0]   flit_vc_o
);

   assign free_o = !flit_valid_o || flit_ready_i;

   // Load a new flit only when free; otherwise hold the pending flit.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         flit_valid_o <= 1'b0;
         flit_o       <= '0;
         flit_vc_o    <= '0;
      end else if (free_o) begin
         flit_valid_o <= load_i;
         if (load_i) begin
            flit_o    <= flit_d_i;
            flit_vc_o <= vc_d_i;
         end
      end
   end

endmodule

// File: rtl/flit_packetizer.sv
// Network-interface transmit packetizer: turns a packet descriptor plus a
// stream of payload words into head/body/tail flits for a router local port.
// Descriptor and payload inputs use valid/ready: a transfer happens on a
// cycle where both are high; valid must not depend on ready.
module flit_packetizer
   import noc_pkg::*;
#(
   parameter int X_W    = 1,
   parameter int Y_W    = 1,
   parameter int VC_W   = 1,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic                      pkt_valid_i,
   output logic                      pkt_ready_o,
   input  logic [X_W-1:0]            pkt_x_i,
   input  logic [Y_W-1:0]            pkt_y_i,
   input  logic [VC_W-1:0]           pkt_vc_i,
   input  logic [LEN_W-1:0]          pkt_len_i,
   input  logic                      data_valid_i,
   output logic                      data_ready_o,
   input  logic [DATA_W-1:0]         data_i,
   output logic                      flit_valid_o,
   input  logic                      flit_ready_i,
   output logic [flit_w(DATA_W)-1:0] flit_o,
   output logic [VC_W-1:0]           flit_vc_o,
   output pkt_state_e                dbg_state_o
);

   localparam int FLIT_W = flit_w(DATA_W);
   localparam int X_MSB  = head_x_msb(DATA_W);
   localparam int Y_MSB  = head_y_msb(DATA_W, X_W);

   pkt_state_e        state_q, state_d;
   logic [X_W-1:0]    x_q;
   logic [Y_W-1:0]    y_q;
   logic [VC_W-1:0]   vc_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              latch_pkt, cnt_load, cnt_dec;
   logic              load, free;
   logic [FLIT_W-1:0] flit_d;
   logic [DATA_W-1:0] head_payload;

   assign dbg_state_o = state_q;

   // Head payload: X then Y from the MSB down, length in the LSBs, rest zero.
   always_comb begin
      head_payload                      = '0;
      head_payload[X_MSB -: X_W]        = x_q;
      head_payload[Y_MSB -: Y_W]        = y_q;
      head_payload[LEN_W-1:0]           = len_q;
   end

   // Next-state, handshake readies and flit selection.
   always_comb begin
      state_d      = state_q;
      pkt_ready_o  = 1'b0;
      data_ready_o = 1'b0;
      load         = 1'b0;
      flit_d       = '0;
      latch_pkt    = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      case (state_q)
         S_IDLE: begin
            pkt_ready_o = 1'b1;
            if (pkt_valid_i) begin
               latch_pkt = 1'b1;
               state_d   = S_HEAD;
            end
         end
         S_HEAD: begin
            if (free) begin
               load = 1'b1;
               if (len_q == '0) begin
                  flit_d  = {FT_HEAD_TAIL, head_payload};
                  state_d = S_IDLE;
               end else begin
                  flit_d   = {FT_HEAD, head_payload};
                  cnt_load = 1'b1;
                  state_d  = S_BODY;
               end
            end
         end
         S_BODY: begin
            data_ready_o = free;
            if (data_valid_i && free) begin
               load    = 1'b1;
               cnt_dec = 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  flit_d  = {FT_TAIL, data_i};
                  state_d = S_IDLE;
               end else begin
                  flit_d = {FT_BODY, data_i};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched descriptor and remaining-word counter.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         vc_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (latch_pkt) begin
            x_q   <= pkt_x_i;
            y_q   <= pkt_y_i;
            vc_q  <= pkt_vc_i;
            len_q <= pkt_len_i;
         end
         if (cnt_load) begin
            cnt_q <= len_q;
         end else if (cnt_dec && cnt_q != '0) begin
            cnt_q <= cnt_q - LEN_W'(1);
         end
      end
   end

   flit_out_reg #(
      .FLIT_W (FLIT_W),
      .VC_W   (VC_W)
   ) u_out_reg (
      .clk          (clk),
      .arst         (arst),
      .load_i       (load),
      .flit_d_i     (flit_d),
      .vc_d_i       (vc_q),
      .flit_ready_i (flit_ready_i),
      .free_o       (free),
      .flit_valid_o (flit_valid_o),
      .flit_o       (flit_o),
      .flit_vc_o    (flit_vc_o)
   );

endmodule

// File: doc/flit_packetizer.md
Name: flit_packetizer

Overview:
Transmit-side counterpart of the input router. It takes a packet descriptor (destination X/Y, VC id, payload length) and a stream of 32-bit payload words. It serialises them into head/body/tail flits in the format the router input stage decodes. It sits in the network interface, between a local master and a router's local input port, and has a one-entry registered output with valid/ready handshake.

Parameters:
X_W, 1, destination X coordinate width
Y_W, 1, destination Y coordinate width
VC_W, 1, virtual-channel id width
LEN_W, 4, payload-length field width (0..2^LEN_W-1 payload words)
DATA_W, 32, payload word width; FLIT_W = DATA_W+2

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous, active-low reset
pkt_valid_i  in  1  descriptor valid
pkt_ready_o  out  1  descriptor accepted when valid&ready
pkt_x_i  in  X_W  destination X
pkt_y_i  in  Y_W  destination Y
pkt_vc_i  in  VC_W  VC id for the whole packet
pkt_len_i  in  LEN_W  number of payload words (0 = head-only packet)
data_valid_i  in  1  payload word valid
data_ready_o  out  1  payload word accepted when valid&ready
data_i  in  DATA_W  payload word
flit_valid_o  out  1  output flit valid
flit_ready_i  in  1  downstream accepts flit
flit_o  out  FLIT_W  flit
flit_vc_o  out  VC_W  VC of current flit

Behaviour:
- Flit type field [FLIT_W-1:FLIT_W-2]: 00 head, 01 body, 10 tail, 11 head+tail (single-flit).
- Head payload layout, from [DATA_W-1] down: X_W bits x dest, then Y_W bits y dest. [LEN_W-1:0] holds len. All other bits are 0.
- Body/tail payload: [DATA_W-1:0] = data word, unmodified.
- Reset (arst=0, async): state IDLE; flit_valid_o=0; flit_o=0; flit_vc_o=0; pkt_ready_o=1; data_ready_o=0; length counter=0.
- Output register is "free" when !flit_valid_o || flit_ready_i. It loads only when free. While flit_valid_o=1 and flit_ready_i=0, flit_o and flit_vc_o are held stable.
- FSM states:
  - IDLE: pkt_ready_o=1, data_ready_o=0. On pkt handshake, latch x/y/vc/len into regs; go to HEAD.
  - HEAD: pkt_ready_o=0. When free, load head flit. Type is 11 if len==0, else 00. flit_vc_o=latched vc. If len==0, go to IDLE; else load cnt=len and go to BODY.
  - BODY: data_ready_o = free (combinational from flit_valid_o/flit_ready_i). On data handshake, load a flit of type 10 if cnt==1, else 01, and decrement cnt. When cnt==1, go to IDLE.
- Latency: pkt handshake at cycle N gives head flit_valid_o at N+2 (IDLE→HEAD at N+1, load at N+1 edge). Data handshake at cycle M gives that flit valid at M+1.
- Throughput: one flit per cycle while data_valid_i=1 and flit_ready_i=1. One idle cycle (no pkt_ready_o) between packets: the tail load cycle moves to IDLE, and the descriptor is accepted the following cycle.
- data_valid_i gaps: no flit is loaded; flit_valid_o drops after the current flit drains. Flits are never duplicated.
- Descriptor inputs are ignored outside IDLE. data_i is ignored outside BODY.
- Destination equal to the local node is still sent; routing is not this block's concern.
- Reset mid-packet: the partial packet is abandoned with no tail. The next packet after reset starts with a head.
- pkt_len_i max 2^LEN_W-1 gives head + that many flits (the last is the tail). The counter never wraps.

Decomposition:
- Shared package (noc_pkg): flit type enum (HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11), FLIT_W, head-field offset constants, FSM state typedef.
- The router input stage imports the same package, so encoder and decoder agree.
- No sub-module required. The output register may optionally be a separate flit_out_reg (one-entry valid/ready holding register).

Test Plan:
- len=0, x=1,y=0,vc=1, flit_ready_i=1 -> exactly one flit, type 11, x field=1, y=0, len field=0, flit_vc_o=1, two cycles after pkt handshake; pkt_ready_o=1 the cycle after load.
- len=3, data 0xA,0xB,0xC continuous -> head(00,len=3), body(01,0xA), body(01,0xB), tail(10,0xC) on consecutive cycles; data_ready_o=0 after third word.
- Same packet, flit_ready_i=0 for 3 cycles while body 0xA is valid -> flit_o stable at 0xA; data_ready_o=0; no word lost; 0xB follows after release.
- data_valid_i toggling 1,0,0,1,1 during BODY -> flits emitted only for valid beats, order preserved, tail on the last word.
- arst asserted during the second body flit of a len=5 packet -> flit_valid_o=0 immediately. After release: pkt_ready_o=1, and the next packet (len=1) emits head then tail with no stale data.
- Back-to-back packets vc=0 len=1 then vc=1 len=2 -> flit_vc_o constant within each packet, switches only at the second head; exactly one bubble cycle between packets.
